// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Architectural register file for the single-cycle processor.
// Two combinational read ports feed the ALU operands, one synchronous write
// port takes the writeback result, and a third combinational port serves
// debug reads. Register 0 is hardwired to zero. A per-register written mask
// and a wrapping accepted-write counter track write activity since reset.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high; clears registers, mask, counter
//   rs1_addr     read port 1 index      -> read_data1
//   rs2_addr     read port 2 index      -> read_data2
//   dbg_addr     debug read index       -> dbg_data
//   reg_write    write enable
//   rd_addr      write index
//   write_data   writeback value
//   written_mask bit i set once register i has accepted a write
//   write_count  accepted writes since reset, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [NUM_REGS-1:0]   written_mask,
    output logic [CNT_WIDTH-1:0]  write_count
);

    // One bit wider than the index so NUM_REGS = 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

    // Register 0 has no storage; the array starts at index 1.
    logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs_r;
    logic [NUM_REGS-1:1]                 mask_r;
    logic [CNT_WIDTH-1:0]                count_r;

    logic                                wr_accept_s;
    logic [NUM_REGS-1:1]                 wr_sel_s;

    // Read mux: index 0 and indices beyond the implemented registers give zero.
    // Searching only the implemented indices avoids any out-of-bounds select.
    function automatic logic [DATA_WIDTH-1:0] read_sel(
        input logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs,
        input logic [ADDR_WIDTH-1:0]               addr
    );
        logic [DATA_WIDTH-1:0] result;
        result = {DATA_WIDTH{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            result = (addr == ADDR_WIDTH'(i)) ? regs[i] : result;
        end
        return result;
    endfunction

    assign read_data1   = read_sel(regs_r, rs1_addr);
    assign read_data2   = read_sel(regs_r, rs2_addr);
    assign dbg_data     = read_sel(regs_r, dbg_addr);
    assign written_mask = {mask_r, 1'b0};
    assign write_count  = count_r;

    // Write qualification: only non-zero, in-range indices are accepted.
    always_comb begin
        wr_accept_s = 1'b0;
        wr_sel_s    = {(NUM_REGS-1){1'b0}};
        if (reg_write && (rd_addr != {ADDR_WIDTH{1'b0}}) &&
            ({1'b0, rd_addr} < NUM_REGS_W)) begin
            wr_accept_s = 1'b1;
            for (int i = 1; i < NUM_REGS; i++) begin
                wr_sel_s[i] = (rd_addr == ADDR_WIDTH'(i));
            end
        end else begin
            wr_accept_s = 1'b0;
        end
    end

    // Register storage: load the selected register on an accepted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_r <= {((NUM_REGS-1)*DATA_WIDTH){1'b0}};
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= wr_sel_s[i] ? write_data : regs_r[i];
            end
        end
    end

    // Written mask: sticky per-register flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= {(NUM_REGS-1){1'b0}};
        end else begin
            mask_r <= mask_r | wr_sel_s;
        end
    end

    // Accepted-write counter: free-running, wraps without saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (wr_accept_s) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Drives one stimulus stream into two reg_file instances: the default
// configuration (A) and a reduced one with 20 registers and a 4-bit counter
// (B), which exercises out-of-range indices and counter wrap. Expected values
// come from array models updated by the architectural write rule; a monitor
// process pops expectations from a queue and compares them with the outputs.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int NB  = 20;
    localparam int CWB = 4;

    logic        clk = 1'b0;
    bit          clk_en = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
    logic        reg_write;
    logic [31:0] write_data;

    logic [31:0] rd1_a, rd2_a, dbg_a, mask_a_o, cnt_a_o;
    logic [31:0] rd1_b, rd2_b, dbg_b;
    logic [NB-1:0]  mask_b_o;
    logic [CWB-1:0] cnt_b_o;

    always #5 if (clk_en) clk = ~clk;

    reg_file dut_a (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .read_data1(rd1_a), .read_data2(rd2_a),
        .reg_write(reg_write), .rd_addr(rd_addr), .write_data(write_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_a),
        .written_mask(mask_a_o), .write_count(cnt_a_o)
    );

    reg_file #(.DATA_WIDTH(32), .NUM_REGS(NB), .ADDR_WIDTH(5), .CNT_WIDTH(CWB)) dut_b (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .read_data1(rd1_b), .read_data2(rd2_b),
        .reg_write(reg_write), .rd_addr(rd_addr), .write_data(write_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_b),
        .written_mask(mask_b_o), .write_count(cnt_b_o)
    );

    // ---------------- reference model ----------------
    bit [31:0]   mem_a [32];
    bit [31:0]   mem_b [NB];
    bit [31:0]   mask_a, mask_b;
    int unsigned cnt_a, cnt_b;

    function automatic logic [31:0] model_rd_a(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem_a[a];
    endfunction

    function automatic logic [31:0] model_rd_b(input logic [4:0] a);
        return (a == 5'd0 || int'(a) >= NB) ? 32'd0 : mem_b[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem_a[i] = 32'd0;
        for (int i = 0; i < NB; i++) mem_b[i] = 32'd0;
        mask_a = 32'd0; mask_b = 32'd0; cnt_a = 0; cnt_b = 0;
    endtask

    task automatic model_write();
        if (reg_write && rd_addr != 5'd0) begin
            mem_a[rd_addr] = write_data;
            mask_a[rd_addr] = 1'b1;
            cnt_a++;
            if (int'(rd_addr) < NB) begin
                mem_b[rd_addr] = write_data;
                mask_b[rd_addr] = 1'b1;
                cnt_b++;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [31:0] a1, a2, ad, am, ac;
        logic [31:0] b1, b2, bd, bm, bc;
    } exp_t;

    exp_t sb [$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input string nm);
        exp_t e;
        e.name = nm;
        e.a1 = model_rd_a(rs1_addr); e.a2 = model_rd_a(rs2_addr); e.ad = model_rd_a(dbg_addr);
        e.am = mask_a; e.ac = cnt_a;
        e.b1 = model_rd_b(rs1_addr); e.b2 = model_rd_b(rs2_addr); e.bd = model_rd_b(dbg_addr);
        e.bm = mask_b; e.bc = cnt_b % (1 << CWB);
        sb.push_back(e);
        -> chk_ev;
        #2;
    endtask

    exp_t me;
    initial begin
        forever begin
            @(chk_ev);
            #1;
            while (sb.size() > 0) begin
                me = sb.pop_front();
                checks++;
                if (rd1_a !== me.a1 || rd2_a !== me.a2 || dbg_a !== me.ad ||
                    mask_a_o !== me.am || cnt_a_o !== me.ac) begin
                    errors++;
                    $display("FAIL %s inst_A got r1=%h r2=%h dbg=%h mask=%h cnt=%h want r1=%h r2=%h dbg=%h mask=%h cnt=%h",
                             me.name, rd1_a, rd2_a, dbg_a, mask_a_o, cnt_a_o,
                             me.a1, me.a2, me.ad, me.am, me.ac);
                end
                checks++;
                if (rd1_b !== me.b1 || rd2_b !== me.b2 || dbg_b !== me.bd ||
                    32'(mask_b_o) !== me.bm || 32'(cnt_b_o) !== me.bc) begin
                    errors++;
                    $display("FAIL %s inst_B got r1=%h r2=%h dbg=%h mask=%h cnt=%h want r1=%h r2=%h dbg=%h mask=%h cnt=%h",
                             me.name, rd1_b, rd2_b, dbg_b, 32'(mask_b_o), 32'(cnt_b_o),
                             me.b1, me.b2, me.bd, me.bm, me.bc);
                end
            end
        end
    end

    // One instruction slot: drive inputs after a falling edge, expect old state
    // before the rising edge and the updated state after it.
    task automatic cycle(input bit we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                         input string nm);
        reg_write = we; rd_addr = rd; write_data = wd;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
        #1;
        push_exp({nm, "_pre"});
        @(posedge clk);
        #1;
        if (!reset) model_write();
        push_exp({nm, "_post"});
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; reg_write = 1'b0; rd_addr = 5'd0; write_data = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; dbg_addr = 5'd0;
        model_clear();
        #1;
        reset = 1'b1;
        #1;
        // Reset with the clock stopped: every index reads zero on every port.
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            push_exp("reset_idle");
        end

        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        cycle(1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  5'd5,  "wr_x5");
        cycle(1'b1, 5'd31, 32'h00000001, 5'd5,  5'd31, 5'd31, "wr_x31");
        cycle(1'b0, 5'd0,  32'h00000000, 5'd5,  5'd31, 5'd5,  "rd_5_31");
        cycle(1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  "wr_x0");
        cycle(1'b1, 5'd7,  32'h00000010, 5'd7,  5'd5,  5'd7,  "wr_x7");
        cycle(1'b1, 5'd7,  32'h00000020, 5'd7,  5'd7,  5'd7,  "rdw_x7");
        cycle(1'b0, 5'd7,  32'h00000099, 5'd7,  5'd7,  5'd7,  "idle_x7");
        cycle(1'b1, 5'd25, 32'h12345678, 5'd25, 5'd19, 5'd25, "wr_x25");

        for (int k = 0; k < 60; k++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 32'($urandom),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), "rand");
        end

        // Ten writes, then an asynchronous reset between edges.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 5'($urandom_range(1, 15)), 32'($urandom),
                  5'($urandom_range(0, 31)), 5'd3, 5'd3, "pre_reset_wr");
        end
        #1;
        reset = 1'b1;
        model_clear();
        rs1_addr = 5'd3; rs2_addr = 5'd5; dbg_addr = 5'd3;
        #1;
        push_exp("reset_async");
        @(negedge clk);
        cycle(1'b1, 5'd3, 32'h00000ABC, 5'd3, 5'd3, 5'd3, "wr_in_reset");
        reset = 1'b0;
        cycle(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd3, 5'd9, "first_after_reset");

        // Sixteen more accepted writes with three x0 writes mixed in.
        for (int k = 0; k < 19; k++) begin
            if (k == 3 || k == 8 || k == 13) begin
                cycle(1'b1, 5'd0, 32'($urandom), 5'd0, 5'd9, 5'd0, "wrap_x0");
            end else begin
                cycle(1'b1, 5'(1 + (k % 15)), 32'($urandom),
                      5'(1 + (k % 15)), 5'd9, 5'd0, "wrap_wr");
            end
        end
        cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd9, 5'd14, "final_idle");

        for (int t = 0; t < 20 && sb.size() > 0; t++) #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
